// File: rtl/req_arbiter_fsm_pkg.sv
// Shared types and constants for the request arbiter: state encoding, widths,
// default hold limit and a one-hot helper.
package req_arbiter_fsm_pkg;

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned MAX_HOLD_DEF = 8;
    localparam int unsigned HOLD_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_arbiter_fsm_if.sv
// Request/grant bundle between the requesting blocks (master) and the
// arbiter (slave).
interface req_arbiter_fsm_if;
    import req_arbiter_fsm_pkg::*;

    logic               en;
    logic               mode;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               hold_expired;

    modport master (
        output en, mode, req,
        input  gnt, gnt_idx, gnt_valid, hold_expired
    );

    modport slave (
        input  en, mode, req,
        output gnt, gnt_idx, gnt_valid, hold_expired
    );

endinterface

// File: rtl/req_arbiter_fsm_prio_enc.sv
// Combinational 4-bit priority encoder with enable; D[3] has highest priority.
module priority_encoder_with_enable
    import req_arbiter_fsm_pkg::*;
(
    input  logic [N_REQ-1:0] D,
    input  logic             EN,
    output logic [IDX_W-1:0] Y,
    output logic             Valid
);

    always_comb begin
        Y     = '0;
        Valid = 1'b0;
        if (EN) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (D[i]) begin
                    Y     = IDX_W'(i);
                    Valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/req_arbiter_fsm.sv
// Four-requester arbiter: fixed-priority or round-robin selection, grant held
// until release or hold limit, one turnaround cycle between grants.
module req_arbiter_fsm
    import req_arbiter_fsm_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
    parameter int unsigned HOLD_W   = HOLD_W_DEF
)
(
    input  logic               clk,
    input  logic               rst_n,
    req_arbiter_fsm_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    w_gnt_nxt;
    logic [IDX_W-1:0]    r_gnt_idx;
    logic [IDX_W-1:0]    w_gnt_idx_nxt;
    logic [IDX_W-1:0]    r_last_idx;
    logic [IDX_W-1:0]    w_last_idx_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                r_hold_expired;
    logic                w_hold_expired_nxt;

    logic [N_REQ-1:0]    w_rr_vec;
    logic [N_REQ-1:0]    w_enc_d;
    logic [IDX_W-1:0]    w_enc_y;
    logic                w_enc_valid;
    logic [IDX_W-1:0]    w_win_idx;

    // Round-robin: the encoder favours D[3], so the rotated vector is also
    // bit-reversed; D[3] = req[last+1], D[0] = req[last], winner = last - Y.
    always_comb begin
        w_rr_vec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_rr_vec[i] = bus.req[r_last_idx - IDX_W'(i)];
        end
    end

    assign w_enc_d   = bus.mode ? w_rr_vec : bus.req;
    assign w_win_idx = bus.mode ? (r_last_idx - w_enc_y) : w_enc_y;

    priority_encoder_with_enable u_prio_enc (
        .D     (w_enc_d),
        .EN    (bus.en),
        .Y     (w_enc_y),
        .Valid (w_enc_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_gnt          <= '0;
            r_gnt_idx      <= '0;
            r_last_idx     <= IDX_W'(N_REQ - 1);
            r_hold_cnt     <= '0;
            r_hold_expired <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_gnt          <= w_gnt_nxt;
            r_gnt_idx      <= w_gnt_idx_nxt;
            r_last_idx     <= w_last_idx_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_hold_expired <= w_hold_expired_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_gnt_nxt          = r_gnt;
        w_gnt_idx_nxt      = r_gnt_idx;
        w_last_idx_nxt     = r_last_idx;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_hold_expired_nxt = 1'b0;

        case (r_state)
            ST_IDLE, ST_COOL: begin
                if (w_enc_valid) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = idx_to_onehot(w_win_idx);
                    w_gnt_idx_nxt  = w_win_idx;
                    w_last_idx_nxt = w_win_idx;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!bus.en) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end else if (!bus.req[r_gnt_idx]) begin
                    w_state_nxt = ST_COOL;
                    w_gnt_nxt   = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt        = ST_COOL;
                    w_gnt_nxt          = '0;
                    w_hold_expired_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign bus.gnt          = r_gnt;
    assign bus.gnt_idx      = r_gnt_idx;
    assign bus.gnt_valid    = |r_gnt;
    assign bus.hold_expired = r_hold_expired;

endmodule

// File: tb/tb_req_arbiter_fsm.sv
// Scoreboard bench for req_arbiter_fsm: each driven cycle queues the expected
// post-edge outputs; a monitor pops and compares one cycle later.
module tb_req_arbiter_fsm;
    import req_arbiter_fsm_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    sb_entry_t sb_q[$];

    req_arbiter_fsm_if bus ();

    req_arbiter_fsm #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pack_out();
        return {bus.hold_expired, bus.gnt_valid, bus.gnt_idx, bus.gnt};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string tag, input logic en, input logic mode,
                        input logic [3:0] req, input logic [3:0] e_gnt,
                        input logic [1:0] e_idx, input logic e_hexp);
        sb_entry_t e;
        bus.en   = en;
        bus.mode = mode;
        bus.req  = req;
        e.tag    = tag;
        e.exp    = {e_hexp, |e_gnt, e_idx, e_gnt};
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            chk(e.tag, pack_out(), e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rr_idx [5];
        rr_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        n_checks = 0;
        n_fail   = 0;

        // Test 1: reset with all requests high
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.mode = 1'b0;
        bus.req  = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out", pack_out(), 8'h00);
        bus.req  = 4'b0001;
        bus.mode = 1'b1;
        rst_n    = 1'b1;
        step("t1_first_gnt", 1, 1, 4'b0001, 4'b0001, 2'd0, 0);
        step("t1_release",   1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        step("t1_idle",      1, 1, 4'b0000, 4'b0000, 2'd0, 0);

        // Test 2: fixed priority, release, turnaround, next winner
        step("t2_gnt3",      1, 0, 4'b1010, 4'b1000, 2'd3, 0);
        step("t2_gnt3_hold", 1, 0, 4'b1010, 4'b1000, 2'd3, 0);
        step("t2_cool",      1, 0, 4'b0010, 4'b0000, 2'd3, 0);
        step("t2_gnt1",      1, 0, 4'b0010, 4'b0010, 2'd1, 0);
        step("t2_release",   1, 0, 4'b0000, 4'b0000, 2'd1, 0);
        step("t2_idle",      1, 0, 4'b0000, 4'b0000, 2'd1, 0);

        // Test 3: hold limit under constant request
        for (int i = 0; i < 8; i++)
            step("t3_hold", 1, 0, 4'b0001, 4'b0001, 2'd0, 0);
        step("t3_expired",   1, 0, 4'b0001, 4'b0000, 2'd0, 1);
        step("t3_regrant",   1, 0, 4'b0001, 4'b0001, 2'd0, 0);
        step("t3_release",   1, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("t3_idle",      1, 0, 4'b0000, 4'b0000, 2'd0, 0);

        // Leave last_idx at 3 so the round-robin sequence starts at index 0
        step("t4_pre_gnt3",  1, 0, 4'b1000, 4'b1000, 2'd3, 0);
        step("t4_pre_rel",   1, 0, 4'b0000, 4'b0000, 2'd3, 0);
        step("t4_pre_idle",  1, 0, 4'b0000, 4'b0000, 2'd3, 0);

        // Test 4: round-robin fairness with all requesting
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++)
                step("t4_rr_gnt", 1, 1, 4'b1111, idx_to_onehot(rr_idx[k]), rr_idx[k], 0);
            step("t4_rr_gap", 1, 1, 4'b1111, 4'b0000, rr_idx[k], 1);
        end
        step("t4_idle",      1, 1, 4'b0000, 4'b0000, 2'd0, 0);

        // Test 5: enable abort
        step("t5_gnt2",      1, 0, 4'b0100, 4'b0100, 2'd2, 0);
        step("t5_gnt2_hold", 1, 0, 4'b0100, 4'b0100, 2'd2, 0);
        step("t5_abort",     0, 0, 4'b0100, 4'b0000, 2'd2, 0);
        for (int i = 0; i < 3; i++)
            step("t5_disabled", 0, 0, 4'b1111, 4'b0000, 2'd2, 0);
        step("t5_reenable",  1, 0, 4'b0100, 4'b0100, 2'd2, 0);
        step("t5_release",   1, 0, 4'b0000, 4'b0000, 2'd2, 0);
        step("t5_idle",      1, 0, 4'b0000, 4'b0000, 2'd2, 0);

        // Test 6: asynchronous reset in the middle of a grant
        step("t6_gnt1",      1, 0, 4'b0010, 4'b0010, 2'd1, 0);
        step("t6_gnt1_hold", 1, 0, 4'b0010, 4'b0010, 2'd1, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", pack_out(), 8'h00);
        rst_n = 1'b1;
        step("t6_rr_first",  1, 1, 4'b1111, 4'b0001, 2'd0, 0);
        step("t6_release",   1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        step("t6_idle",      1, 1, 4'b0000, 4'b0000, 2'd0, 0);

        chk("sb_drain", 8'(sb_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
